// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned o = i1 - i2 - bin, one bit per clock, start/done handshake.
// Optional saturating mode when SERIAL_SUB_SAT_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a, b, d, br_next;
    logic [WIDTH-1:0] diff;

    assign a       = a_sr[0];
    assign b       = b_sr[0];
    assign d       = a ^ b ^ br;
    assign br_next = (~a & b) | (~(a ^ b) & br);
    assign diff    = {d, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            o     <= '0;
            bout  <= 1'b0;
        end else if (state == RUN) begin
            res  <= diff;
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            br   <= br_next;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_SUB_SAT_EN
                o <= br_next ? '0 : diff;
`else
                o <= diff;
`endif
                bout  <= br_next;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
            end
        end else begin
            // IDLE and DONE both accept a new request
            done  <= 1'b0;
            busy  <= start;
            state <= start ? RUN : IDLE;
            if (start) begin
                a_sr <= i1;
                b_sr <= i2;
                br   <= bin;
                res  <= '0;
                cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor (WIDTH=4 and WIDTH=8 instances).
module tb_serial_subtractor;
`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] i1 = '0, i2 = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [3:0] o;

    logic       start8 = 1'b0;
    logic [7:0] i1_8 = '0, i2_8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] o8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .i1(i1), .i2(i2), .bin(bin),
        .busy(busy), .done(done), .o(o), .bout(bout)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .i1(i1_8), .i2(i2_8), .bin(1'b0),
        .busy(busy8), .done(done8), .o(o8), .bout(bout8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [3:0] eo, input logic eb, input string nm);
        int  edges;
        bit  busy_bad;
        i1 = a; i2 = b; bin = c; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && edges < 20) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            edges++;
        end
        checks++;
        if (edges !== 5) begin
            failures++;
            $display("FAIL %s latency: got %0d edges, expected 5", nm, edges);
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL %s busy: busy dropped before done, expected 1 during RUN", nm);
        end
        checks++;
        if (o !== eo || bout !== eb || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s result: o=%h bout=%b busy=%b, expected o=%h bout=%b busy=0",
                     nm, o, bout, busy, eo, eb);
        end
        tick();
        checks++;
        if (done !== 1'b0 || o !== eo || bout !== eb) begin
            failures++;
            $display("FAIL %s hold: done=%b o=%h bout=%b, expected done=0 o=%h bout=%b",
                     nm, done, o, bout, eo, eb);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || o !== 4'h0 || bout !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b o=%h bout=%b, expected all 0", busy, done, o, bout);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || o8 !== 8'h0 || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL reset8: busy=%b done=%b o=%h bout=%b, expected all 0", busy8, done8, o8, bout8);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, "sub_9_3");
        run_op(4'd3, 4'd9, 1'b0, SAT ? 4'h0 : 4'hA, 1'b1, "sub_3_9");
        run_op(4'd0, 4'd0, 1'b1, SAT ? 4'h0 : 4'hF, 1'b1, "sub_0_0_b");
        run_op(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, "sub_f_f");
        run_op(4'd12, 4'd5, 1'b1, 4'h6, 1'b0, "sub_12_5_b");
    endtask

    task automatic test_back_to_back();
        int         d1 = -1, d2 = -1;
        logic [3:0] o1 = 'x, o2 = 'x;
        logic       b1 = 'x, b2 = 'x;
        i1 = 4'd5; i2 = 4'd2; bin = 1'b0; start = 1'b1;
        tick();
        i1 = 4'd7; i2 = 4'd7;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (done === 1'b1) begin
                if (d1 < 0) begin d1 = t; o1 = o; b1 = bout; end
                else if (d2 < 0) begin d2 = t; o2 = o; b2 = bout; end
            end
            if (t == 5) start = 1'b0;
        end
        checks++;
        if (d1 !== 4 || d2 !== 9) begin
            failures++;
            $display("FAIL b2b spacing: done at cycles %0d,%0d, expected 4,9", d1, d2);
        end
        checks++;
        if (o1 !== 4'h3 || b1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b first: o=%h bout=%b, expected o=3 bout=0", o1, b1);
        end
        checks++;
        if (o2 !== 4'h0 || b2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b second: o=%h bout=%b, expected o=0 bout=0", o2, b2);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen = 1'b0;
        run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, "pre_reset");
        i1 = 4'd13; i2 = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || o !== 4'h0 || bout !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b done=%b o=%h bout=%b, expected all 0", busy, done, o, bout);
        end
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_reset quiet: done/busy=1 seen after reset, expected 0 until new start");
        end
        run_op(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, "post_reset");
    endtask

    task automatic test_width8();
        int edges;
        i1_8 = 8'd255; i2_8 = 8'd1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        i1_8 = 8'd0;
        edges = 1;
        while (done8 !== 1'b1 && edges < 30) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 9) begin
            failures++;
            $display("FAIL w8 latency: got %0d edges, expected 9", edges);
        end
        checks++;
        if (o8 !== 8'd254 || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL w8 result: o=%0d bout=%b, expected o=254 bout=0", o8, bout8);
        end
        i1_8 = 8'd16; i2_8 = 8'd32; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (8) tick();
        checks++;
        if (done8 !== 1'b1 || o8 !== (SAT ? 8'd0 : 8'd240) || bout8 !== 1'b1) begin
            failures++;
            $display("FAIL w8 borrow: done=%b o=%0d bout=%b, expected done=1 o=%0d bout=1",
                     done8, o8, bout8, SAT ? 0 : 240);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
